// File: rtl/pulse_period_meter_if.sv
// Result bus of the pulse period meter: measured period with valid/ready handshake plus status flags.
// PULSE_METER_CHECK_EN adds the target-period input and the mismatch flag.
interface pulse_period_meter_if #(
    parameter int N = 8
);
    logic [N-1:0] period;
    logic         period_valid;
    logic         period_ready;
    logic         timeout;
    logic         overrun;
`ifdef PULSE_METER_CHECK_EN
    logic [N-1:0] expected;
    logic         mismatch;
`endif

    modport master (
        output period,
        output period_valid,
        input  period_ready,
        output timeout,
        output overrun
`ifdef PULSE_METER_CHECK_EN
        ,
        input  expected,
        output mismatch
`endif
    );

    modport slave (
        input  period,
        input  period_valid,
        output period_ready,
        input  timeout,
        input  overrun
`ifdef PULSE_METER_CHECK_EN
        ,
        output expected,
        input  mismatch
`endif
    );
endinterface

// File: rtl/pulse_period_meter.sv
// Measures cycles between consecutive pulse events; period/valid registered, visible the cycle after the event.
// Result held while valid && !ready; a capture over an unaccepted result sets sticky overrun. Option: PULSE_METER_CHECK_EN.
module pulse_period_meter #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 in,
    pulse_period_meter_if.master pm
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        MEASURE
    } state_t;

    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_ONE = N'(1);

    state_t       state, state_nxt;
    logic [N-1:0] count, count_nxt;
    logic [N-1:0] period_q, period_nxt;
    logic         valid_q, valid_nxt;
    logic         timeout_q, timeout_nxt;
    logic         overrun_q, overrun_nxt;
    logic         capture;
`ifdef PULSE_METER_CHECK_EN
    logic         mismatch_q, mismatch_nxt;
`endif

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        period_nxt  = period_q;
        valid_nxt   = valid_q;
        timeout_nxt = 1'b0;
        overrun_nxt = overrun_q;
        capture     = 1'b0;

        if (valid_q && pm.period_ready)
            valid_nxt = 1'b0;

        // Disabling drops any in-flight measurement but leaves the result handshake alive.
        if (!ena) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            case (state)
                IDLE: state_nxt = WAIT_FIRST;
                WAIT_FIRST: begin
                    if (in) begin
                        count_nxt = CNT_ONE;
                        state_nxt = MEASURE;
                    end
                end
                MEASURE: begin
                    if (in) begin
                        capture   = 1'b1;
                        count_nxt = CNT_ONE;
                    end else if (count == CNT_MAX) begin
                        timeout_nxt = 1'b1;
                        count_nxt   = '0;
                        state_nxt   = WAIT_FIRST;
                    end else begin
                        count_nxt = count + CNT_ONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // A capture coinciding with an accept simply replaces the result.
        if (capture) begin
            period_nxt = count;
            valid_nxt  = 1'b1;
            if (valid_q && !pm.period_ready)
                overrun_nxt = 1'b1;
        end
    end

`ifdef PULSE_METER_CHECK_EN
    always_comb begin
        mismatch_nxt = mismatch_q;
        if (capture)
            mismatch_nxt = (count != pm.expected);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PULSE_METER_CHECK_EN
            mismatch_q <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            period_q  <= period_nxt;
            valid_q   <= valid_nxt;
            timeout_q <= timeout_nxt;
            overrun_q <= overrun_nxt;
`ifdef PULSE_METER_CHECK_EN
            mismatch_q <= mismatch_nxt;
`endif
        end
    end

    assign pm.period       = period_q;
    assign pm.period_valid = valid_q;
    assign pm.timeout      = timeout_q;
    assign pm.overrun      = overrun_q;
`ifdef PULSE_METER_CHECK_EN
    assign pm.mismatch     = mismatch_q;
`endif
endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: vector table, directed corner sequences, then random traffic vs a timestamp model.
module tb_pulse_period_meter;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    logic pin;
    int   checks = 0;
    int   errors = 0;

    pulse_period_meter_if #(.N(N)) pif ();

    pulse_period_meter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .in  (pin),
        .pm  (pif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         r, e, i, y;
        logic [N-1:0] period;
        logic         valid, timeout, overrun;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic e, logic i, logic y,
                                int p, logic v, logic t, logic o);
        vec_t x;
        x.r = r; x.e = e; x.i = i; x.y = y;
        x.period = p[N-1:0]; x.valid = v; x.timeout = t; x.overrun = o;
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return at the next falling edge.
    task automatic cyc(input logic r, input logic e, input logic i, input logic y);
        rst = r; ena = e; pin = i; pif.period_ready = y;
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input int p, input int v, input int t, input int o);
        chk({tag, ".period"},  int'(pif.period), p);
        chk({tag, ".valid"},   int'(pif.period_valid), v);
        chk({tag, ".timeout"}, int'(pif.timeout), t);
        chk({tag, ".overrun"}, int'(pif.overrun), o);
    endtask

    // Reference model state, in terms of event timestamps rather than a counter.
    int     m_n;
    logic   m_live;
    logic   m_have_ref;
    int     m_ref_t;
    int     m_period;
    logic   m_valid, m_timeout, m_overrun;

    task automatic model_step(input logic r, input logic e, input logic i, input logic y);
        logic active;
        logic ev;
        if (r) begin
            m_live = 0; m_have_ref = 0; m_period = 0;
            m_valid = 0; m_timeout = 0; m_overrun = 0;
        end else begin
            active    = m_live && e;
            ev        = active && i;
            m_timeout = 0;
            if (ev && m_have_ref) begin
                if (m_valid && !y) m_overrun = 1;
                m_period = m_n - m_ref_t;
                m_valid  = 1;
            end else if (m_valid && y) begin
                m_valid = 0;
            end
            if (ev) begin
                m_have_ref = 1;
                m_ref_t    = m_n;
            end else if (active && m_have_ref && (m_n - m_ref_t) == (1 << N) - 1) begin
                m_timeout  = 1;
                m_have_ref = 0;
            end
            if (!active) m_have_ref = 0;
            m_live = e;
        end
        m_n++;
    endtask

    initial begin
        int to_at;
        int to_cnt;
        int density;
        logic r, e, i, y;

        rst = 1; ena = 0; pin = 0; pif.period_ready = 0;
`ifdef PULSE_METER_CHECK_EN
        pif.expected = 8'd10;
`endif
        @(negedge clk);
        cyc(1, 0, 0, 0);
        chk_out("reset", 0, 0, 0, 0);

        // Table: held-high burst, overrun/accept, disable and re-enable.
        tbl.push_back(mk(1,0,0,1, 0,0,0,0));
        tbl.push_back(mk(0,1,0,1, 0,0,0,0));
        tbl.push_back(mk(0,1,1,1, 0,0,0,0));
        tbl.push_back(mk(0,1,1,1, 1,1,0,0));
        tbl.push_back(mk(0,1,1,1, 1,1,0,0));
        tbl.push_back(mk(0,1,1,1, 1,1,0,0));
        tbl.push_back(mk(0,1,0,1, 1,0,0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,1,0, 0,0,0,0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0,1,0,0, 0,0,0,0));
        tbl.push_back(mk(0,1,1,0, 4,1,0,0));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(0,1,0,0, 4,1,0,0));
        tbl.push_back(mk(0,1,1,0, 6,1,0,1));
        tbl.push_back(mk(0,1,0,1, 6,0,0,1));
        tbl.push_back(mk(0,1,0,0, 6,0,0,1));
        tbl.push_back(mk(0,0,1,0, 6,0,0,1));
        tbl.push_back(mk(0,1,1,0, 6,0,0,1));
        tbl.push_back(mk(0,1,1,0, 6,0,0,1));
        tbl.push_back(mk(0,1,1,0, 1,1,0,1));
        foreach (tbl[k]) begin
            cyc(tbl[k].r, tbl[k].e, tbl[k].i, tbl[k].y);
            chk_out($sformatf("vec%0d", k), tbl[k].period, tbl[k].valid,
                    tbl[k].timeout, tbl[k].overrun);
        end

        // Spacing 5, twice, with a consumer always ready.
        cyc(1, 0, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 1, 1);
        for (int k = 0; k < 4; k++) cyc(0, 1, 0, 1);
        chk("p5.before", int'(pif.period_valid), 0);
        cyc(0, 1, 1, 1);
        chk("p5.first.valid", int'(pif.period_valid), 1);
        chk("p5.first.period", int'(pif.period), 5);
        cyc(0, 1, 0, 1);
        chk("p5.accepted", int'(pif.period_valid), 0);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 1);
        cyc(0, 1, 1, 1);
        chk("p5.second.valid", int'(pif.period_valid), 1);
        chk("p5.second.period", int'(pif.period), 5);

        // Longest measurable period: event on the last count is a capture, not a timeout.
        cyc(1, 0, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 1, 1);
        for (int k = 0; k < 254; k++) cyc(0, 1, 0, 1);
        cyc(0, 1, 1, 1);
        chk("max.period", int'(pif.period), 255);
        chk("max.valid", int'(pif.period_valid), 1);
        chk("max.timeout", int'(pif.timeout), 0);

        // Timeout 256 cycles after the last event, then re-reference.
        cyc(1, 0, 0, 1);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 1, 1);
        to_at = -1; to_cnt = 0;
        for (int k = 1; k < 300; k++) begin
            cyc(0, 1, 0, 1);
            if (pif.timeout) begin
                to_cnt++;
                if (to_at < 0) to_at = k + 1;
            end
        end
        chk("to.cycle", to_at, 256);
        chk("to.pulses", to_cnt, 1);
        cyc(0, 1, 1, 1);
        chk("to.rearm.nocap", int'(pif.period_valid), 0);
        for (int k = 0; k < 6; k++) cyc(0, 1, 0, 1);
        cyc(0, 1, 1, 1);
        chk("to.rearm.valid", int'(pif.period_valid), 1);
        chk("to.rearm.period", int'(pif.period), 7);

        // Reset mid-measurement with a pending result and overrun.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        chk_out("rst.pre", 4, 1, 0, 1);
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0);
        cyc(1, 1, 1, 0);
        chk_out("rst.post", 0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        chk("rst.ref.nocap", int'(pif.period_valid), 0);
        cyc(0, 1, 1, 0);
        chk("rst.cap.valid", int'(pif.period_valid), 1);
        chk("rst.cap.period", int'(pif.period), 1);

`ifdef PULSE_METER_CHECK_EN
        cyc(1, 0, 0, 1);
        chk("mm.reset", int'(pif.mismatch), 0);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 1, 1);
        for (int k = 0; k < 9; k++) cyc(0, 1, 0, 1);
        cyc(0, 1, 1, 1);
        chk("mm.p10.period", int'(pif.period), 10);
        chk("mm.p10", int'(pif.mismatch), 0);
        for (int k = 0; k < 8; k++) cyc(0, 1, 0, 1);
        cyc(0, 1, 1, 1);
        chk("mm.p9.period", int'(pif.period), 9);
        chk("mm.p9", int'(pif.mismatch), 1);
`endif

        // Random traffic against the timestamp model.
        m_n = 0;
        m_ref_t = 0;
        cyc(1, 0, 0, 0);
        model_step(1, 0, 0, 0);
        density = 2;
        for (int c = 0; c < 6000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: density = 2;
                    1: density = 8;
                    2: density = 60;
                    default: density = 400;
                endcase
            end
            r = ($urandom_range(0, 999) == 0);
            e = ($urandom_range(0, 79) != 0);
            i = ($urandom_range(0, density - 1) == 0);
            y = ($urandom_range(0, 2) != 0);
            cyc(r, e, i, y);
            model_step(r, e, i, y);
            chk("rnd.period",  int'(pif.period), m_period);
            chk("rnd.valid",   int'(pif.period_valid), int'(m_valid));
            chk("rnd.timeout", int'(pif.timeout), int'(m_timeout));
            chk("rnd.overrun", int'(pif.overrun), int'(m_overrun));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
